// File: rtl/bus_responder.sv
// Target-side endpoint for the packed bus word {rw, addr[11:0], data[11:0]}:
// accepts one word, performs a local register-file read or write, then returns one response beat.
module bus_responder #(
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] bus_in,
    input  logic        bus_valid,
    output logic        bus_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [11:0] rsp_data,
    output logic        rsp_wr,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t state;
    state_t next_state;

    logic        lat_rw;
    logic [11:0] lat_addr;
    logic [11:0] lat_data;

    logic [11:0] mem [DEPTH];

    logic                  accept;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] index;
    logic                  mem_we;

    // Window decode works on the latched address, so bus_in may change freely after accept.
    assign hit    = (lat_addr[11:DEPTH_LOG2] == BASE_ADDR[11:DEPTH_LOG2]);
    assign index  = lat_addr[DEPTH_LOG2-1:0];
    assign mem_we = (state == ACCESS) && lat_rw && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bus_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                bus_ready = 1'b1;
                if (bus_valid) begin
                    accept     = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                next_state = RESPOND;
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rw   <= 1'b0;
            lat_addr <= 12'h000;
            lat_data <= 12'h000;
        end else if (accept) begin
            lat_rw   <= bus_in[24];
            lat_addr <= bus_in[23:12];
            lat_data <= bus_in[11:0];
        end
    end

    // Reset wins over an ACCESS-cycle write, so a write racing reset never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 12'h000;
            end
        end else if (mem_we) begin
            mem[index] <= lat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= 12'h000;
            rsp_wr   <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_wr  <= lat_rw;
            rsp_err <= !hit;
            if (lat_rw) begin
                rsp_data <= lat_data;
            end else if (hit) begin
                rsp_data <= mem[index];
            end else begin
                rsp_data <= 12'hFFF;
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: vector table of single transactions plus
// hand sequences for backpressure, reset during ACCESS and a back-to-back stream.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] bus_in;
    logic        bus_valid;
    logic        bus_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_err;

    int checks = 0;
    int passes = 0;

    logic [11:0] model_mem [16];
    logic [11:0] got_data;
    logic        got_err;
    logic        got_wr;

    typedef struct {
        string       name;
        logic        rw;
        logic [11:0] addr;
        logic [11:0] data;
        logic [11:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    bus_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_wr    (rsp_wr),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual %0h expected %0h", name, actual, expected);
        end
    endtask

    // One full transaction from IDLE; checks ready, 2-edge latency, then completes the response.
    task automatic applyStimulus(input logic rw, input logic [11:0] addr, input logic [11:0] data,
                                 input string name, output logic [11:0] o_data,
                                 output logic o_err, output logic o_wr);
        @(negedge clk);
        checkOutput({name, " bus_ready"}, {31'd0, bus_ready}, 32'd1);
        bus_in    = {rw, addr, data};
        bus_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_valid = 1'b0;
        bus_in    = ~{rw, addr, data};
        checkOutput({name, " no early rsp"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput({name, " rsp latency"}, {31'd0, rsp_valid}, 32'd1);
        o_data    = rsp_data;
        o_err     = rsp_err;
        o_wr      = rsp_wr;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (rw && addr < 12'h010) begin
            model_mem[addr[3:0]] = data;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] stream_vals [4];
        int sent;
        int got;
        int cyc;
        int last_acc;

        vecs[0] = '{"wr 003",      1'b1, 12'h003, 12'hABC, 12'hABC, 1'b0};
        vecs[1] = '{"rd 003",      1'b0, 12'h003, 12'h000, 12'hABC, 1'b0};
        vecs[2] = '{"rd 004",      1'b0, 12'h004, 12'h000, 12'h000, 1'b0};
        vecs[3] = '{"wr 010 miss", 1'b1, 12'h010, 12'h123, 12'h123, 1'b1};
        vecs[4] = '{"rd 010 miss", 1'b0, 12'h010, 12'h000, 12'hFFF, 1'b1};
        vecs[5] = '{"wr 00F",      1'b1, 12'h00F, 12'h7E7, 12'h7E7, 1'b0};
        vecs[6] = '{"rd 00F",      1'b0, 12'h00F, 12'h000, 12'h7E7, 1'b0};
        vecs[7] = '{"wr FFF miss", 1'b1, 12'hFFF, 12'h111, 12'h111, 1'b1};
        vecs[8] = '{"rd 800 miss", 1'b0, 12'h800, 12'h000, 12'hFFF, 1'b1};
        vecs[9] = '{"rd 003 again",1'b0, 12'h003, 12'h5A5, 12'hABC, 1'b0};

        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 12'h000;
        end

        rst       = 1'b1;
        bus_in    = '0;
        bus_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_data", {20'd0, rsp_data}, 32'h000);
        checkOutput("reset rsp_wr", {31'd0, rsp_wr}, 32'd0);
        checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset bus_ready", {31'd0, bus_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].name, got_data, got_err, got_wr);
            checkOutput({vecs[i].name, " data"}, {20'd0, got_data}, {20'd0, vecs[i].exp_data});
            checkOutput({vecs[i].name, " err"}, {31'd0, got_err}, {31'd0, vecs[i].exp_err});
            checkOutput({vecs[i].name, " wr"}, {31'd0, got_wr}, {31'd0, vecs[i].rw});
        end

        // Miss writes above must not have disturbed any word in the window.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 12'(k), 12'h000, "sweep", got_data, got_err, got_wr);
            checkOutput($sformatf("sweep word %0d", k), {20'd0, got_data}, {20'd0, model_mem[k]});
        end

        // Response backpressure with a competing word on the bus.
        @(negedge clk);
        bus_in    = {1'b1, 12'h005, 12'h5A5};
        bus_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_in = {1'b1, 12'h005, 12'h111};
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("bp rsp_valid %0d", n), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("bp rsp_data %0d", n), {20'd0, rsp_data}, 32'h5A5);
            checkOutput($sformatf("bp bus_ready %0d", n), {31'd0, bus_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("bp release bus_ready", {31'd0, bus_ready}, 32'd1);
        bus_valid = 1'b0;
        rsp_ready = 1'b0;
        model_mem[5] = 12'h5A5;
        applyStimulus(1'b0, 12'h005, 12'h000, "bp readback", got_data, got_err, got_wr);
        checkOutput("bp readback data", {20'd0, got_data}, 32'h5A5);

        // Reset lands in the ACCESS cycle of a write.
        @(negedge clk);
        bus_in    = {1'b1, 12'h001, 12'h555};
        bus_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_valid = 1'b0;
        checkOutput("rst-mid in access", {31'd0, bus_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checkOutput($sformatf("rst-mid rsp_valid %0d", n), {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 12'h000;
        end
        applyStimulus(1'b0, 12'h001, 12'h000, "rst-mid rd 001", got_data, got_err, got_wr);
        checkOutput("rst-mid rd 001 data", {20'd0, got_data}, 32'h000);
        applyStimulus(1'b0, 12'h003, 12'h000, "rst-mid rd 003", got_data, got_err, got_wr);
        checkOutput("rst-mid rd 003 data", {20'd0, got_data}, 32'h000);

        // Back-to-back write/read pairs with rsp_ready held high.
        stream_vals[0] = 12'h1A1;
        stream_vals[1] = 12'h2B2;
        stream_vals[2] = 12'h3C3;
        stream_vals[3] = 12'h4D4;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        last_acc  = 0;
        rsp_ready = 1'b1;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            if (rsp_valid) begin
                checkOutput($sformatf("stream rsp %0d data", got), {20'd0, rsp_data}, {20'd0, stream_vals[got / 2]});
                checkOutput($sformatf("stream rsp %0d wr", got), {31'd0, rsp_wr}, {31'd0, (got % 2) == 0});
                checkOutput($sformatf("stream rsp %0d err", got), {31'd0, rsp_err}, 32'd0);
                got++;
            end
            if (bus_ready) begin
                if (sent < 8) begin
                    if (sent > 0) begin
                        checkOutput($sformatf("stream spacing %0d", sent), cyc - last_acc, 32'd3);
                    end
                    last_acc  = cyc;
                    bus_in    = {(sent % 2) == 0, 12'h008 + 12'(sent / 2), stream_vals[sent / 2]};
                    bus_valid = 1'b1;
                    sent++;
                end else begin
                    bus_valid = 1'b0;
                end
            end
            cyc++;
        end
        checkOutput("stream response count", got, 32'd8);
        rsp_ready = 1'b0;
        bus_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
# bus_responder

Target-side endpoint for the 25-bit packed bus word `{rw, addr[11:0], data[11:0]}`. The block accepts one bus word per valid/ready handshake and unpacks it. It then performs a write to, or a read from, a small local register file mapped at a parameterised base address. Each transaction returns exactly one response beat (read data or write acknowledge, plus an error flag) over a second valid/ready handshake. It sits between the packed-bus initiator and local storage, and forms the receive end of the bus-word protocol.

## Interface
- `BASE_ADDR`, default 12'h000: base of the mapped window; only bits [11:DEPTH_LOG2] are compared.
- `DEPTH_LOG2`, default 4: log2 of register-file depth (16 words × 12 bits); legal range 1..11.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `bus_in`  in  25  packed word: [24] rw (1 = write, 0 = read), [23:12] addr, [11:0] data.
- `bus_valid`  in  1  initiator presents `bus_in`.
- `bus_ready`  out  1  responder can accept a word.
- `rsp_valid`  out  1  response beat present.
- `rsp_ready`  in  1  initiator accepts response.
- `rsp_data`  out  12  read data; for writes, the data written.
- `rsp_wr`  out  1  echo of rw for the transaction.
- `rsp_err`  out  1  address outside mapped window.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - `bus_ready`=1.
  - On `bus_valid & bus_ready`, latch rw, addr and data into internal registers, then go to ACCESS.
  - With no handshake, stay in IDLE.
- ACCESS (always exactly 1 cycle):
  - Compute hit = (addr[11:DEPTH_LOG2] == BASE_ADDR[11:DEPTH_LOG2]); index = addr[DEPTH_LOG2-1:0].
  - Write hit: `mem[index]` ← data; `rsp_data` ← data; `rsp_err` ← 0.
  - Write miss: memory unchanged; `rsp_data` ← data; `rsp_err` ← 1.
  - Read hit: `rsp_data` ← `mem[index]` (the value before any write in this cycle); `rsp_err` ← 0.
  - Read miss: `rsp_data` ← 12'hFFF; `rsp_err` ← 1.
  - `rsp_wr` ← rw. Go to RESPOND.
- RESPOND:
  - `rsp_valid`=1; `rsp_data`, `rsp_wr` and `rsp_err` hold stable.
  - On `rsp_ready`=1, go to IDLE.
  - Otherwise hold indefinitely; no timeout.
- `bus_ready`=0 in ACCESS and RESPOND. One transaction is outstanding at most; no buffering.
- `bus_in` is sampled only on the accepting edge. Later changes on `bus_in` have no effect.
- Register file is 2^DEPTH_LOG2 × 12 bits and is cleared to 0 by reset.

## Timing
- Reset (`rst`=1 at an edge), regardless of state:
  - State → IDLE.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_wr`=0, `rsp_err`=0.
  - All memory words = 0.
  - `bus_ready`=1 from the first cycle after reset deasserts.
- Reset has priority over every transition. If `rst` and the ACCESS write fall on the same edge, the write does not occur and memory clears. A pending response is discarded without a handshake.
- Latency, accept edge to `rsp_valid`=1: 2 edges (ACCESS, then RESPOND registered).
- Minimum occupancy is 3 cycles per transaction when `rsp_ready` is held at 1. Peak throughput is 1 transaction per 3 cycles.
- The RESPOND → IDLE edge does not accept a bus word, because `bus_ready` is 0 in that cycle. The next accept occurs no earlier than the following edge.
- `bus_valid` deasserting while `bus_ready`=0 is legal and is ignored.
- Read-after-write to the same address in back-to-back transactions returns the new value.
- Address boundaries:
  - addr = BASE_ADDR + 2^DEPTH_LOG2 − 1 is a hit.
  - The next address is a miss.
  - The window does not wrap.

## Test plan
- Reset, then write: assert `rst` 2 cycles, release; send {1, 12'h003, 12'hABC}. Require:
  - `bus_ready`=1 in IDLE.
  - `rsp_valid` 2 edges after accept, with `rsp_data`=ABC, `rsp_wr`=1, `rsp_err`=0.
- Read-back: read {0, 12'h003, x}. Require `rsp_data`=ABC and `rsp_err`=0. A read of an unwritten addr 12'h004 returns 000.
- Out-of-range: with BASE_ADDR=0 and DEPTH_LOG2=4:
  - Write 12'h010 → `rsp_err`=1, and no word changes (all 16 words read back unchanged).
  - Read 12'h010 → `rsp_data`=FFF, `rsp_err`=1.
  - Addr 12'h00F → hit.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles. Require `rsp_valid` and `rsp_data` stable, `bus_ready`=0, and a new `bus_valid` word not accepted. Then release `rsp_ready`: IDLE follows on the next edge.
- Reset mid-transaction: assert `rst` in the ACCESS cycle of a write of 555 to addr 1. Require `rsp_valid` never asserts, and a subsequent read of addr 1 returns 000.
- Back-to-back stream with `rsp_ready`=1: 4 alternating write/read pairs. Require an accept exactly every 3 cycles and in-order responses matching the written data.
